reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 31 +++
 rtl/reg_file_if.sv | 41 ++++
 rtl/reg_file.sv | 88 ++++++++
 tb/tb_reg_file.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and types for the architectural register file and rename-tag table.
// Tag layout is {busy, rob_pos}; the busy flag is the MSB of a ROB id.
package reg_file_pkg;

    localparam int unsigned REG_POS_WID = 5;
    localparam int unsigned ROB_POS_WID = 4;
    localparam int unsigned ROB_ID_WID  = ROB_POS_WID + 1;
    localparam int unsigned BUSY_BIT    = ROB_ID_WID - 1;
    localparam int unsigned DATA_WID    = 32;

    typedef logic [REG_POS_WID-1:0] reg_pos_t;
    typedef logic [ROB_POS_WID-1:0] rob_pos_t;
    typedef logic [ROB_ID_WID-1:0]  rob_id_t;
    typedef logic [DATA_WID-1:0]    data_t;

    typedef struct packed {
        data_t   val;
        rob_id_t rob_id;
    } query_t;

    function automatic rob_id_t make_rob_id(input logic busy, input rob_pos_t pos);
        rob_id_t id;
        id = '0;
        if (busy) begin
            id[BUSY_BIT]           = 1'b1;
            id[ROB_POS_WID-1:0]    = pos;
        end
        return id;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decoder / issue / commit bundle between the core front end, the ROB and the register file.
// master = core side driving queries and updates, slave = register file.
interface reg_file_if;
    import reg_file_pkg::*;

    logic     rdy;
    logic     rollback;

    reg_pos_t reg_rs1;
    data_t    reg_rs1_val;
    rob_id_t  reg_rs1_rob_id;
    reg_pos_t reg_rs2;
    data_t    reg_rs2_val;
    rob_id_t  reg_rs2_rob_id;

    logic     issue;
    reg_pos_t issue_rd;
    rob_pos_t issue_rob_pos;

    logic     commit;
    reg_pos_t commit_rd;
    rob_pos_t commit_rob_pos;
    data_t    commit_val;

    modport master (
        output rdy, rollback,
        output reg_rs1, reg_rs2,
        input  reg_rs1_val, reg_rs1_rob_id, reg_rs2_val, reg_rs2_rob_id,
        output issue, issue_rd, issue_rob_pos,
        output commit, commit_rd, commit_rob_pos, commit_val
    );

    modport slave (
        input  rdy, rollback,
        input  reg_rs1, reg_rs2,
        output reg_rs1_val, reg_rs1_rob_id, reg_rs2_val, reg_rs2_rob_id,
        input  issue, issue_rd, issue_rob_pos,
        input  commit, commit_rd, commit_rob_pos, commit_val
    );

endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags. Queries are combinational and
// bypass a same-cycle commit that frees the pending producer.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM   = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROB_POS_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);

    logic [DATA_W-1:0]    val  [REG_NUM];
    logic [REG_NUM-1:0]   busy;
    logic [ROB_POS_W-1:0] tag  [REG_NUM];

    logic   commit_en;
    query_t q1;
    query_t q2;

    assign commit_en = bus.commit && bus.rdy;

    function automatic query_t query(
        input reg_pos_t rs,
        input data_t    rs_val,
        input logic     rs_busy,
        input rob_pos_t rs_tag,
        input logic     c_en,
        input reg_pos_t c_rd,
        input rob_pos_t c_pos,
        input data_t    c_val
    );
        query_t q;
        q.val    = rs_val;
        q.rob_id = make_rob_id(rs_busy, rs_tag);
        if (rs == '0) begin
            q.val    = '0;
            q.rob_id = '0;
        end else if (c_en && (c_rd == rs) && rs_busy && (rs_tag == c_pos)) begin
            // Producer retires this cycle: hand out its value instead of a dying tag.
            q.val    = c_val;
            q.rob_id = '0;
        end
        return q;
    endfunction

    always_comb begin
        q1 = query(bus.reg_rs1, val[bus.reg_rs1], busy[bus.reg_rs1], tag[bus.reg_rs1],
                   commit_en, bus.commit_rd, bus.commit_rob_pos, bus.commit_val);
        q2 = query(bus.reg_rs2, val[bus.reg_rs2], busy[bus.reg_rs2], tag[bus.reg_rs2],
                   commit_en, bus.commit_rd, bus.commit_rob_pos, bus.commit_val);
    end

    assign bus.reg_rs1_val    = q1.val;
    assign bus.reg_rs1_rob_id = q1.rob_id;
    assign bus.reg_rs2_val    = q2.val;
    assign bus.reg_rs2_rob_id = q2.rob_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val[i] <= '0;
                tag[i] <= '0;
            end
        end else if (bus.rdy) begin
            // x0 is never written, so it keeps its reset value of zero and never turns busy.
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                if (bus.commit && (bus.commit_rd == reg_pos_t'(i))) begin
                    val[i] <= bus.commit_val;
                    if (tag[i] == bus.commit_rob_pos) begin
                        busy[i] <= 1'b0;
                    end
                end
                if (bus.issue && !bus.rollback && (bus.issue_rd == reg_pos_t'(i))) begin
                    busy[i] <= 1'b1;
                    tag[i]  <= bus.issue_rob_pos;
                end
            end
            if (bus.rollback) begin
                busy <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized checks of reg_file against a behavioural model of the tag table.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_if bus ();

    reg_file #(
        .REG_NUM   (32),
        .DATA_W    (32),
        .ROB_POS_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    data_t    mval  [32];
    logic     mbusy [32];
    rob_pos_t mtag  [32];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mval[i]  = '0;
            mbusy[i] = 1'b0;
            mtag[i]  = '0;
        end
    endtask

    // Architectural effect of one clock edge, applied in program order: commit, issue, flush.
    task automatic model_clock();
        if (bus.rdy) begin
            if (bus.commit && bus.commit_rd != 0) begin
                mval[bus.commit_rd] = bus.commit_val;
                if (mtag[bus.commit_rd] == bus.commit_rob_pos) mbusy[bus.commit_rd] = 1'b0;
            end
            if (bus.issue && bus.issue_rd != 0 && !bus.rollback) begin
                mbusy[bus.issue_rd] = 1'b1;
                mtag[bus.issue_rd]  = bus.issue_rob_pos;
            end
            if (bus.rollback) begin
                for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
            end
        end
    endtask

    task automatic expect_port(input string nm, input reg_pos_t rs, input data_t oval,
                               input rob_id_t oid);
        data_t   ev;
        rob_id_t eid;
        if (rs == 0) begin
            ev  = '0;
            eid = '0;
        end else if (bus.rdy && bus.commit && bus.commit_rd == rs && mbusy[rs] &&
                     mtag[rs] == bus.commit_rob_pos) begin
            ev  = bus.commit_val;
            eid = '0;
        end else begin
            ev  = mval[rs];
            eid = mbusy[rs] ? {1'b1, mtag[rs]} : 5'd0;
        end
        chk({nm, "_val"}, oval, ev);
        chk({nm, "_id"}, 32'(oid), 32'(eid));
    endtask

    task automatic chk_q();
        expect_port("rs1", bus.reg_rs1, bus.reg_rs1_val, bus.reg_rs1_rob_id);
        expect_port("rs2", bus.reg_rs2, bus.reg_rs2_val, bus.reg_rs2_rob_id);
    endtask

    task automatic cycle();
        #1;
        chk_q();
        @(posedge clk);
        if (rst) model_clock();
        #1;
    endtask

    task automatic idle();
        bus.rdy            = 1'b1;
        bus.rollback       = 1'b0;
        bus.issue          = 1'b0;
        bus.issue_rd       = '0;
        bus.issue_rob_pos  = '0;
        bus.commit         = 1'b0;
        bus.commit_rd      = '0;
        bus.commit_rob_pos = '0;
        bus.commit_val     = '0;
    endtask

    task automatic do_issue(input reg_pos_t rd, input rob_pos_t pos);
        bus.issue = 1'b1; bus.issue_rd = rd; bus.issue_rob_pos = pos;
    endtask

    task automatic do_commit(input reg_pos_t rd, input rob_pos_t pos, input data_t v);
        bus.commit = 1'b1; bus.commit_rd = rd; bus.commit_rob_pos = pos; bus.commit_val = v;
    endtask

    task automatic rand_cycle();
        reg_pos_t crd;
        bus.rdy      = ($urandom_range(0, 7) != 0);
        bus.rollback = ($urandom_range(0, 15) == 0);
        bus.issue    = $urandom_range(0, 1) == 1;
        bus.issue_rd = reg_pos_t'($urandom_range(0, 7));
        bus.issue_rob_pos = rob_pos_t'($urandom);
        crd = reg_pos_t'($urandom_range(0, 7));
        bus.commit     = $urandom_range(0, 1) == 1;
        bus.commit_rd  = crd;
        bus.commit_rob_pos = ($urandom_range(0, 2) != 0) ? mtag[crd] : rob_pos_t'($urandom);
        bus.commit_val = $urandom;
        bus.reg_rs1 = ($urandom_range(0, 1) == 1) ? crd : reg_pos_t'($urandom_range(0, 7));
        bus.reg_rs2 = reg_pos_t'($urandom);
        cycle();
    endtask

    initial begin
        model_reset();
        idle();
        bus.reg_rs1 = 5'd5;
        bus.reg_rs2 = 5'd0;
        #3;
        chk("rst_x5_val", bus.reg_rs1_val, 32'h0);
        chk("rst_x5_id", 32'(bus.reg_rs1_rob_id), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Issue x5 -> busy with tag 3.
        do_issue(5'd5, 4'd3);
        cycle();
        idle();
        bus.reg_rs1 = 5'd5;
        #1 chk("x5_busy_id", 32'(bus.reg_rs1_rob_id), 32'h13);
        cycle();

        // Commit of the current producer is bypassed in the same cycle.
        do_commit(5'd5, 4'd3, 32'h1234);
        #1;
        chk("x5_bypass_val", bus.reg_rs1_val, 32'h1234);
        chk("x5_bypass_id", 32'(bus.reg_rs1_rob_id), 32'h0);
        cycle();
        idle();
        #1;
        chk("x5_commit_val", bus.reg_rs1_val, 32'h1234);
        chk("x5_commit_id", 32'(bus.reg_rs1_rob_id), 32'h0);
        cycle();

        // Stale commit leaves the younger tag in place.
        do_issue(5'd7, 4'd2); cycle(); idle();
        do_issue(5'd7, 4'd6); cycle(); idle();
        bus.reg_rs1 = 5'd7;
        do_commit(5'd7, 4'd2, 32'hAA); cycle(); idle();
        #1;
        chk("x7_stale_val", bus.reg_rs1_val, 32'hAA);
        chk("x7_stale_id", 32'(bus.reg_rs1_rob_id), 32'h16);
        cycle();

        // Same-cycle commit and issue to x9: issue wins the tag.
        do_issue(5'd9, 4'd1); cycle(); idle();
        bus.reg_rs1 = 5'd9;
        do_commit(5'd9, 4'd1, 32'h55);
        do_issue(5'd9, 4'd4);
        cycle(); idle();
        #1;
        chk("x9_both_val", bus.reg_rs1_val, 32'h55);
        chk("x9_both_id", 32'(bus.reg_rs1_rob_id), 32'h14);
        cycle();

        // Rollback clears tags, keeps values, and the same-cycle commit still lands.
        do_issue(5'd3, 4'd8); cycle(); idle();
        do_issue(5'd4, 4'd9);
        do_commit(5'd3, 4'd15, 32'h33);
        cycle(); idle();
        bus.rollback = 1'b1;
        do_commit(5'd10, 4'd0, 32'h77);
        do_issue(5'd11, 4'd5);
        cycle(); idle();
        bus.reg_rs1 = 5'd3;
        bus.reg_rs2 = 5'd4;
        #1;
        chk("x3_rb_val", bus.reg_rs1_val, 32'h33);
        chk("x3_rb_id", 32'(bus.reg_rs1_rob_id), 32'h0);
        chk("x4_rb_id", 32'(bus.reg_rs2_rob_id), 32'h0);
        bus.reg_rs1 = 5'd10;
        bus.reg_rs2 = 5'd11;
        #1;
        chk("x10_rb_val", bus.reg_rs1_val, 32'h77);
        chk("x11_rb_id", 32'(bus.reg_rs2_rob_id), 32'h0);
        cycle();

        // x0 ignores writes and tags.
        do_issue(5'd0, 4'd1);
        do_commit(5'd0, 4'd1, 32'hFFFF);
        bus.reg_rs1 = 5'd0;
        cycle(); idle();
        #1;
        chk("x0_val", bus.reg_rs1_val, 32'h0);
        chk("x0_id", 32'(bus.reg_rs1_rob_id), 32'h0);

        // rdy=0 freezes state and disables the bypass.
        bus.rdy = 1'b0;
        do_issue(5'd8, 4'd2);
        cycle(); idle();
        bus.reg_rs1 = 5'd8;
        #1 chk("x8_frozen_id", 32'(bus.reg_rs1_rob_id), 32'h0);
        do_issue(5'd12, 4'd5); cycle(); idle();
        bus.rdy = 1'b0;
        bus.reg_rs1 = 5'd12;
        do_commit(5'd12, 4'd5, 32'h99);
        #1;
        chk("x12_nobyp_val", bus.reg_rs1_val, 32'h0);
        chk("x12_nobyp_id", 32'(bus.reg_rs1_rob_id), 32'h15);
        cycle(); idle();

        for (int n = 0; n < 400; n++) rand_cycle();

        // Asynchronous reset mid-run clears everything without a clock edge.
        idle();
        do_issue(5'd6, 4'd7); cycle(); idle();
        bus.reg_rs1 = 5'd6;
        bus.reg_rs2 = 5'd9;
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_x6_id", 32'(bus.reg_rs1_rob_id), 32'h0);
        chk("arst_x9_val", bus.reg_rs2_val, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 100; n++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
